// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with flush and an optional 2-entry skid buffer
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous squash of held and incoming beats
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload (always the main register)
//   count                 held beats, 0..2 (0..1 when SKID=0)
module pipe_skid_reg #(
  parameter int DATA_W         = 32,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] main_q, skid_q;
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q, in_xfer, out_xfer;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = main_q;
  assign count     = cnt_q;
  // With a skid entry, ready is a flop so no stall path runs from out_ready to in_ready.
  assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign cnt_d     = flush ? 2'd0 : cnt_q + 2'(in_xfer) - 2'(out_xfer);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != 2'd2;
      if (flush) begin
        if (CLEAR_ON_FLUSH != 0) begin
          main_q <= '0;
          skid_q <= '0;
        end
      end else begin
        // main takes the new beat when empty or when its current beat leaves this edge;
        // otherwise a departing main is refilled from the skid entry.
        if (in_xfer && (cnt_q == 2'd0 || out_xfer)) main_q <= in_data;
        else if (cnt_q == 2'd2 && out_xfer) main_q <= skid_q;
        if (SKID != 0 && in_xfer && cnt_q == 2'd1 && !out_xfer) skid_q <= in_data;
      end
    end
endmodule
